// File: rtl/enemy_move_controller_if.sv
// Control/status bundle between the game logic and one enemy motion sequencer.
interface enemy_move_controller_if;
    logic        startOfFrame;
    logic        enable;
    logic        collision;
    logic [3:0]  hitEdgeCode;
    logic        enemyHit;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic [3:0]  direction;
    logic        visible;
    logic        alive;

    modport master (
        output startOfFrame, enable, collision, hitEdgeCode, enemyHit,
        input  topLeftX, topLeftY, direction, visible, alive
    );

    modport slave (
        input  startOfFrame, enable, collision, hitEdgeCode, enemyHit,
        output topLeftX, topLeftY, direction, visible, alive
    );
endinterface

// File: rtl/enemy_move_controller.sv
// Per-enemy motion sequencer: steps once per frame, bounces off walls, runs the death blink.
// All outputs registered; position/direction update one clk after the qualifying startOfFrame.
module enemy_move_controller #(
    parameter logic [10:0] INIT_X       = 11'd64,
    parameter logic [10:0] INIT_Y       = 11'd64,
    parameter int          SPEED        = 2,
    parameter logic [10:0] MIN_X        = 11'd32,
    parameter logic [10:0] MAX_X        = 11'd576,
    parameter logic [10:0] MIN_Y        = 11'd32,
    parameter logic [10:0] MAX_Y        = 11'd416,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5,
    parameter int          BLINK_FRAMES = 4,
    parameter int          DYING_FRAMES = 48
) (
    input  logic                   clk,
    input  logic                   resetN,
    enemy_move_controller_if.slave ctl
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MOVE  = 3'd1;
    localparam logic [2:0] S_TURN  = 3'd2;
    localparam logic [2:0] S_DYING = 3'd3;
    localparam logic [2:0] S_DEAD  = 3'd4;

    localparam logic [3:0] DIR_LEFT   = 4'b1000;
    localparam logic [3:0] DIR_TOP    = 4'b0100;
    localparam logic [3:0] DIR_RIGHT  = 4'b0010;
    localparam logic [3:0] DIR_BOTTOM = 4'b0001;

    localparam int          CW         = $clog2(DYING_FRAMES + 1);
    localparam logic [CW-1:0] LAST_FRAME = CW'(DYING_FRAMES - 1);
    localparam logic [11:0] STEP       = 12'(SPEED);

    logic [2:0]    r_state;
    logic [10:0]   r_x, r_y;
    logic [3:0]    r_dir;
    logic          r_visible, r_alive, r_flag;
    logic [CW-1:0] r_frame_cnt;
    logic [7:0]    r_lfsr;

    logic          w_sof_go, w_face_hit, w_flag, w_in_range, w_blink_edge;
    logic [3:0]    w_step_dir, w_lfsr_dir, w_turn_dir;
    logic [11:0]   w_cand_x, w_cand_y;
    logic [31:0]   w_blink_mod;

    function automatic logic [3:0] f_opposite(input logic [3:0] d);
        return {d[1:0], d[3:2]};
    endfunction

    assign w_sof_go   = ctl.startOfFrame & ctl.enable;
    assign w_face_hit = ctl.collision & (|(ctl.hitEdgeCode & r_dir));
    // A facing hit in the same cycle as the frame strobe still counts as a collision.
    assign w_flag     = r_flag | w_face_hit;
    assign w_step_dir = w_flag ? f_opposite(r_dir) : r_dir;
    assign w_lfsr_dir = DIR_LEFT >> r_lfsr[1:0];
    assign w_turn_dir = (w_lfsr_dir == r_dir) ? f_opposite(r_dir) : w_lfsr_dir;
    assign w_blink_mod  = 32'(r_frame_cnt) % 32'(BLINK_FRAMES);
    assign w_blink_edge = (w_blink_mod == 32'(BLINK_FRAMES - 1));

    // 12-bit candidate so an underflow lands far above MAX and fails the range check.
    always_comb begin
        w_cand_x = {1'b0, r_x};
        w_cand_y = {1'b0, r_y};
        case (w_step_dir)
            DIR_LEFT:   w_cand_x = {1'b0, r_x} - STEP;
            DIR_RIGHT:  w_cand_x = {1'b0, r_x} + STEP;
            DIR_TOP:    w_cand_y = {1'b0, r_y} - STEP;
            DIR_BOTTOM: w_cand_y = {1'b0, r_y} + STEP;
            default: ;
        endcase
        w_in_range = (w_cand_x >= {1'b0, MIN_X}) && (w_cand_x <= {1'b0, MAX_X}) &&
                     (w_cand_y >= {1'b0, MIN_Y}) && (w_cand_y <= {1'b0, MAX_Y});
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_x         <= INIT_X;
            r_y         <= INIT_Y;
            r_dir       <= DIR_LEFT;
            r_visible   <= 1'b1;
            r_alive     <= 1'b1;
            r_flag      <= 1'b0;
            r_frame_cnt <= '0;
            r_lfsr      <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            case (r_state)
                S_DYING: begin
                    if (ctl.startOfFrame) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        if (w_blink_edge)
                            r_visible <= ~r_visible;
                        if (r_frame_cnt == LAST_FRAME) begin
                            r_state   <= S_DEAD;
                            r_visible <= 1'b0;
                            r_alive   <= 1'b0;
                        end
                    end
                end
                S_DEAD: begin
                    r_visible <= 1'b0;
                    r_alive   <= 1'b0;
                end
                default: begin
                    if (ctl.enemyHit) begin
                        r_state     <= S_DYING;
                        r_frame_cnt <= '0;
                        r_flag      <= 1'b0;
                    end else begin
                        case (r_state)
                            S_MOVE: begin
                                if (w_sof_go) begin
                                    if (w_in_range) begin
                                        r_x <= w_cand_x[10:0];
                                        r_y <= w_cand_y[10:0];
                                    end
                                    r_flag <= 1'b0;
                                    if (w_flag || !w_in_range)
                                        r_state <= S_TURN;
                                end else if (w_face_hit) begin
                                    r_flag <= 1'b1;
                                end
                            end
                            S_TURN: begin
                                r_dir   <= w_turn_dir;
                                r_state <= S_MOVE;
                            end
                            default: begin
                                r_flag  <= 1'b0;
                                r_state <= ctl.enable ? S_MOVE : S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign ctl.topLeftX  = r_x;
    assign ctl.topLeftY  = r_y;
    assign ctl.direction = r_dir;
    assign ctl.visible   = r_visible;
    assign ctl.alive     = r_alive;
endmodule

// File: tb/tb_enemy_move_controller.sv
// Bench for enemy_move_controller: default instance A plus instance B started near the left wall.
module tb_enemy_move_controller;
    logic       clk = 1'b0;
    logic       resetN;
    logic       sof, en, col, hit;
    logic [3:0] edge_code;
    int         checks = 0;
    int         errors = 0;
    logic [10:0] exp_x_q[$];
    logic [10:0] exp_x;

    always #5 clk = ~clk;

    enemy_move_controller_if if_a();
    enemy_move_controller_if if_b();

    assign if_a.startOfFrame = sof;
    assign if_a.enable       = en;
    assign if_a.collision    = col;
    assign if_a.hitEdgeCode  = edge_code;
    assign if_a.enemyHit     = hit;
    assign if_b.startOfFrame = sof;
    assign if_b.enable       = en;
    assign if_b.collision    = col;
    assign if_b.hitEdgeCode  = edge_code;
    assign if_b.enemyHit     = hit;

    enemy_move_controller dut_a (.clk(clk), .resetN(resetN), .ctl(if_a));
    enemy_move_controller #(.INIT_X(11'd34)) dut_b (.clk(clk), .resetN(resetN), .ctl(if_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic apply_reset();
        sof = 0; en = 0; col = 0; hit = 0; edge_code = 4'b0000;
        resetN = 1'b0;
        #12;
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (if_a.topLeftX !== 11'd64 || if_a.topLeftY !== 11'd64) begin
            errors++; $display("FAIL reset_pos: got %0d,%0d expected 64,64", if_a.topLeftX, if_a.topLeftY);
        end
        checks++;
        if (if_a.direction !== 4'b1000) begin
            errors++; $display("FAIL reset_dir: got %b expected 1000", if_a.direction);
        end
        checks++;
        if (if_a.visible !== 1'b1 || if_a.alive !== 1'b1) begin
            errors++; $display("FAIL reset_flags: visible=%b alive=%b expected 1 1", if_a.visible, if_a.alive);
        end
        checks++;
        if (if_b.topLeftX !== 11'd34) begin
            errors++; $display("FAIL reset_init_b: got %0d expected 34", if_b.topLeftX);
        end
    endtask

    task automatic test_move();
        en = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            exp_x_q.push_back(11'(64 - 2 * i));
            pulse_sof();
            exp_x = exp_x_q.pop_front();
            checks++;
            if (if_a.topLeftX !== exp_x) begin
                errors++; $display("FAIL move_step%0d: got %0d expected %0d", i, if_a.topLeftX, exp_x);
            end
        end
        checks++;
        if (if_a.topLeftY !== 11'd64 || if_a.direction !== 4'b1000 || if_a.visible !== 1'b1 || if_a.alive !== 1'b1) begin
            errors++;
            $display("FAIL move_other: y=%0d dir=%b vis=%b alive=%b expected 64 1000 1 1",
                     if_a.topLeftY, if_a.direction, if_a.visible, if_a.alive);
        end
    endtask

    task automatic test_wrong_side();
        col = 1'b1; edge_code = 4'b0010;
        tick();
        col = 1'b0; edge_code = 4'b0000;
        exp_x_q.push_back(11'd56);
        pulse_sof();
        exp_x = exp_x_q.pop_front();
        checks++;
        if (if_a.topLeftX !== exp_x) begin
            errors++; $display("FAIL wrong_side_step: got %0d expected %0d", if_a.topLeftX, exp_x);
        end
        tick();
        checks++;
        if (if_a.direction !== 4'b1000) begin
            errors++; $display("FAIL wrong_side_dir: got %b expected 1000", if_a.direction);
        end
        exp_x_q.push_back(11'd54);
        pulse_sof();
        exp_x = exp_x_q.pop_front();
        checks++;
        if (if_a.topLeftX !== exp_x) begin
            errors++; $display("FAIL wrong_side_next: got %0d expected %0d", if_a.topLeftX, exp_x);
        end
    endtask

    task automatic test_facing_collision();
        col = 1'b1; edge_code = 4'b1000;
        tick();
        col = 1'b0; edge_code = 4'b0000;
        exp_x_q.push_back(11'd56);
        pulse_sof();
        exp_x = exp_x_q.pop_front();
        checks++;
        if (if_a.topLeftX !== exp_x || if_a.direction !== 4'b1000) begin
            errors++; $display("FAIL collide_undo: x=%0d dir=%b expected %0d 1000", if_a.topLeftX, if_a.direction, exp_x);
        end
        tick();
        checks++;
        if (!$onehot(if_a.direction) || if_a.direction === 4'b1000 || if_a.topLeftX !== 11'd56) begin
            errors++; $display("FAIL collide_turn: x=%0d dir=%b expected 56 and one-hot not 1000", if_a.topLeftX, if_a.direction);
        end
    endtask

    task automatic test_enable_low();
        apply_reset();
        for (int i = 0; i < 5; i++) pulse_sof();
        checks++;
        if (if_a.topLeftX !== 11'd64) begin
            errors++; $display("FAIL idle_disabled: got %0d expected 64", if_a.topLeftX);
        end
        en = 1'b1;
        tick();
        pulse_sof();
        en = 1'b0;
        for (int i = 0; i < 5; i++) pulse_sof();
        checks++;
        if (if_a.topLeftX !== 11'd62 || if_a.topLeftY !== 11'd64) begin
            errors++; $display("FAIL move_disabled: got %0d,%0d expected 62,64", if_a.topLeftX, if_a.topLeftY);
        end
        col = 1'b1; edge_code = 4'b1000;
        tick();
        col = 1'b0; edge_code = 4'b0000;
        tick();
        en = 1'b1;
        pulse_sof();
        checks++;
        if (if_a.topLeftX !== 11'd64) begin
            errors++; $display("FAIL flag_while_disabled: got %0d expected 64", if_a.topLeftX);
        end
    endtask

    task automatic test_bound();
        logic bad;
        apply_reset();
        en = 1'b1;
        tick();
        pulse_sof();
        checks++;
        if (if_b.topLeftX !== 11'd32) begin
            errors++; $display("FAIL bound_reach_min: got %0d expected 32", if_b.topLeftX);
        end
        pulse_sof();
        checks++;
        if (if_b.topLeftX !== 11'd32 || if_b.direction !== 4'b1000) begin
            errors++; $display("FAIL bound_hold: x=%0d dir=%b expected 32 1000", if_b.topLeftX, if_b.direction);
        end
        tick();
        checks++;
        if (!$onehot(if_b.direction) || if_b.direction === 4'b1000 || if_b.topLeftX !== 11'd32) begin
            errors++; $display("FAIL bound_turn: x=%0d dir=%b expected 32 and one-hot not 1000", if_b.topLeftX, if_b.direction);
        end
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            pulse_sof();
            tick();
            if (if_b.topLeftX < 11'd32 || if_b.topLeftX > 11'd576 ||
                if_b.topLeftY < 11'd32 || if_b.topLeftY > 11'd416) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL bound_range: left the legal area, last x=%0d y=%0d", if_b.topLeftX, if_b.topLeftY);
        end
    endtask

    task automatic test_hit_dying();
        logic vis_exp, alive_exp;
        logic bad;
        apply_reset();
        en = 1'b1;
        tick();
        pulse_sof();
        pulse_sof();
        hit = 1'b1; sof = 1'b1;
        tick();
        hit = 1'b0; sof = 1'b0;
        checks++;
        if (if_a.topLeftX !== 11'd60 || if_a.direction !== 4'b1000 || if_a.alive !== 1'b1) begin
            errors++; $display("FAIL hit_freeze: x=%0d dir=%b alive=%b expected 60 1000 1", if_a.topLeftX, if_a.direction, if_a.alive);
        end
        vis_exp = 1'b1;
        bad = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            if (k == 20) hit = 1'b1;
            pulse_sof();
            hit = 1'b0;
            if (k < 48 && (k % 4) == 0) vis_exp = ~vis_exp;
            if (k == 48) vis_exp = 1'b0;
            alive_exp = (k < 48);
            checks++;
            if (if_a.visible !== vis_exp || if_a.alive !== alive_exp) begin
                errors++;
                $display("FAIL dying_frame%0d: visible=%b alive=%b expected %b %b", k, if_a.visible, if_a.alive, vis_exp, alive_exp);
            end
            if (if_a.topLeftX !== 11'd60) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL dying_pos: position moved while dying, x=%0d expected 60", if_a.topLeftX);
        end
        hit = 1'b1; col = 1'b1; edge_code = 4'b1000; sof = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        hit = 1'b0; col = 1'b0; edge_code = 4'b0000; sof = 1'b0;
        checks++;
        if (if_a.visible !== 1'b0 || if_a.alive !== 1'b0 || if_a.topLeftX !== 11'd60) begin
            errors++; $display("FAIL dead_sticky: vis=%b alive=%b x=%0d expected 0 0 60", if_a.visible, if_a.alive, if_a.topLeftX);
        end
    endtask

    task automatic test_reset_in_dying();
        apply_reset();
        en = 1'b1;
        tick();
        pulse_sof();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 5; i++) pulse_sof();
        checks++;
        if (if_a.visible !== 1'b0 || if_a.topLeftX !== 11'd62) begin
            errors++; $display("FAIL pre_reset_dying: vis=%b x=%0d expected 0 62", if_a.visible, if_a.topLeftX);
        end
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if (if_a.topLeftX !== 11'd64 || if_a.topLeftY !== 11'd64 || if_a.direction !== 4'b1000 ||
            if_a.visible !== 1'b1 || if_a.alive !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_dying: x=%0d y=%0d dir=%b vis=%b alive=%b expected 64 64 1000 1 1",
                     if_a.topLeftX, if_a.topLeftY, if_a.direction, if_a.visible, if_a.alive);
        end
        #3;
        resetN = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_move();
        test_wrong_side();
        test_facing_collision();
        test_enable_low();
        test_bound();
        test_hit_dying();
        test_reset_in_dying();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
